// File: rtl/mmio_pkg.sv
//==============================================================================
// Module      : mmio_pkg
// Description : Shared types and constants for the MMIO bus bridge.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package mmio_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WDATA  = 3'd1,
    ST_ACCESS = 3'd2,
    ST_RESP   = 3'd3,
    ST_ERR    = 3'd4
  } mmio_state_t;

  localparam int SLOT_W = 4;
  localparam int OFFS_W = 6;
  localparam int CNT_W  = 8;

  localparam logic [SLOT_W-1:0] MMIO_SLOT_UART   = 4'd0;
  localparam logic [SLOT_W-1:0] MMIO_SLOT_TIMER  = 4'd1;
  localparam logic [SLOT_W-1:0] MMIO_SLOT_GPIO   = 4'd2;
  localparam logic [SLOT_W-1:0] MMIO_SLOT_SYSCTL = 4'd3;

  function automatic logic slot_mapped(input logic [SLOT_W-1:0] slot, input int nslots);
    return int'(slot) < nslots;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bus_mmio.sv
//==============================================================================
// Module      : bus_mmio
// Description : Single-outstanding MMIO bridge from bus_main to 256-byte
//               peripheral slots with req/ack handshake and timeout.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module bus_mmio
  import mmio_pkg::*;
#(
  parameter int NSLOTS  = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk_core,
  input  logic                 reset_n,
  input  logic                 bmain_cvalid_bmmio,
  output logic                 bmmio_cready,
  input  logic                 bmain_cmd,
  input  logic [25:0]          bmain_addr,
  input  logic                 bmain_wvalid_bmmio,
  output logic                 bmmio_wready,
  input  logic                 bmain_wlast,
  input  logic [31:0]          bmain_wdata,
  input  logic [3:0]           bmain_wmask,
  output logic                 bmmio_rvalid,
  input  logic                 bmain_rready_bmmio,
  output logic [31:0]          bmmio_rdata,
  output logic                 bmmio_error,
  input  logic                 bmain_eack_bmmio,
  output logic [NSLOTS-1:0]    periph_req,
  output logic                 periph_we,
  output logic [OFFS_W-1:0]    periph_addr,
  output logic [31:0]          periph_wdata,
  output logic [3:0]           periph_wmask,
  input  logic [NSLOTS-1:0]    periph_ack,
  input  logic [NSLOTS*32-1:0] periph_rdata
);

  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT - 1);

  mmio_state_t              r_state;
  mmio_state_t              w_state_next;
  logic                     r_cmd;
  logic [SLOT_W+OFFS_W-1:0] r_addr;
  logic [31:0]              r_wdata;
  logic [3:0]               r_wmask;
  logic [31:0]              r_rdata;
  logic [CNT_W-1:0]         r_cnt;

  logic [SLOT_W-1:0]        w_slot;
  logic [NSLOTS-1:0]        w_req;
  logic                     w_ack;
  logic [31:0]              w_slot_rdata;
  logic                     w_unused_addr;

  assign w_slot        = r_addr[SLOT_W+OFFS_W-1:OFFS_W];
  assign w_unused_addr = ^bmain_addr[25:SLOT_W+OFFS_W];

  // Only the selected slot's ack can complete the access.
  always_comb begin
    w_req = '0;
    if (r_state == ST_ACCESS) w_req = NSLOTS'(1) << w_slot;
  end
  assign w_ack        = |(periph_ack & w_req);
  assign w_slot_rdata = periph_rdata[{w_slot, 5'b00000} +: 32];

  always_ff @(posedge clk_core) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bmain_cvalid_bmmio) begin
          if (!bmain_cmd)
            w_state_next = ST_WDATA;
          else if (slot_mapped(bmain_addr[SLOT_W+OFFS_W-1:OFFS_W], NSLOTS))
            w_state_next = ST_ACCESS;
          else
            w_state_next = ST_ERR;
        end
      end
      ST_WDATA: begin
        if (bmain_wvalid_bmmio) begin
          if (!bmain_wlast || !slot_mapped(w_slot, NSLOTS)) w_state_next = ST_ERR;
          else                                              w_state_next = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        // Ack wins over a timeout landing in the same cycle.
        if (w_ack)                   w_state_next = r_cmd ? ST_RESP : ST_IDLE;
        else if (r_cnt == c_cnt_last) w_state_next = ST_ERR;
      end
      ST_RESP: if (bmain_rready_bmmio) w_state_next = ST_IDLE;
      ST_ERR:  if (bmain_eack_bmmio)   w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_core) begin
    if (!reset_n) begin
      r_cmd   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wmask <= '0;
      r_rdata <= '0;
      r_cnt   <= '0;
    end else begin
      if (r_state == ST_IDLE && bmain_cvalid_bmmio) begin
        r_cmd  <= bmain_cmd;
        r_addr <= bmain_addr[SLOT_W+OFFS_W-1:0];
      end
      if (r_state == ST_WDATA && bmain_wvalid_bmmio) begin
        r_wdata <= bmain_wdata;
        r_wmask <= bmain_wmask;
      end
      if (r_state == ST_ACCESS && w_ack && r_cmd) r_rdata <= w_slot_rdata;
      // Held at zero outside ACCESS, so every entry starts a fresh count.
      if (r_state == ST_ACCESS) r_cnt <= r_cnt + 1'b1;
      else                      r_cnt <= '0;
    end
  end

  assign bmmio_cready = (r_state == ST_IDLE);
  assign bmmio_wready = (r_state == ST_WDATA);
  assign bmmio_rvalid = (r_state == ST_RESP);
  assign bmmio_error  = (r_state == ST_ERR);
  assign bmmio_rdata  = r_rdata;
  assign periph_req   = w_req;
  assign periph_we    = (r_state == ST_ACCESS) && !r_cmd;
  assign periph_addr  = r_addr[OFFS_W-1:0];
  assign periph_wdata = r_wdata;
  assign periph_wmask = r_wmask;

endmodule

`default_nettype wire

// File: tb/tb_bus_mmio.sv
//==============================================================================
// Module      : tb_bus_mmio
// Description : Directed self-checking bench for bus_mmio.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_bus_mmio;

  localparam int NSLOTS = 4;

  logic                 clk_core = 1'b0;
  logic                 reset_n;
  logic                 bmain_cvalid_bmmio, bmain_cmd, bmain_wvalid_bmmio, bmain_wlast;
  logic                 bmain_rready_bmmio, bmain_eack_bmmio;
  logic [25:0]          bmain_addr;
  logic [31:0]          bmain_wdata;
  logic [3:0]           bmain_wmask;
  logic                 bmmio_cready, bmmio_wready, bmmio_rvalid, bmmio_error, periph_we;
  logic [31:0]          bmmio_rdata, periph_wdata;
  logic [NSLOTS-1:0]    periph_req, periph_ack;
  logic [5:0]           periph_addr;
  logic [3:0]           periph_wmask;
  logic [NSLOTS*32-1:0] periph_rdata;

  int n_tot = 0;
  int n_bad = 0;
  int req_cycles;

  bus_mmio #(.NSLOTS(NSLOTS), .TIMEOUT(8)) dut (
    .clk_core(clk_core), .reset_n(reset_n),
    .bmain_cvalid_bmmio(bmain_cvalid_bmmio), .bmmio_cready(bmmio_cready),
    .bmain_cmd(bmain_cmd), .bmain_addr(bmain_addr),
    .bmain_wvalid_bmmio(bmain_wvalid_bmmio), .bmmio_wready(bmmio_wready),
    .bmain_wlast(bmain_wlast), .bmain_wdata(bmain_wdata), .bmain_wmask(bmain_wmask),
    .bmmio_rvalid(bmmio_rvalid), .bmain_rready_bmmio(bmain_rready_bmmio),
    .bmmio_rdata(bmmio_rdata), .bmmio_error(bmmio_error),
    .bmain_eack_bmmio(bmain_eack_bmmio),
    .periph_req(periph_req), .periph_we(periph_we), .periph_addr(periph_addr),
    .periph_wdata(periph_wdata), .periph_wmask(periph_wmask),
    .periph_ack(periph_ack), .periph_rdata(periph_rdata)
  );

  always #5 clk_core = ~clk_core;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_core);
    #1;
  endtask

  // Issue a command beat; returns with the DUT one cycle past acceptance.
  task automatic send_cmd(input logic rd, input logic [31:0] byte_addr);
    bmain_cvalid_bmmio = 1'b1;
    bmain_cmd          = rd;
    bmain_addr         = byte_addr[27:2];
    tick();
    bmain_cvalid_bmmio = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_cready"}, bmmio_cready, 1'b1);
    chk({tag, "_error"},  bmmio_error,  1'b0);
    chk({tag, "_rvalid"}, bmmio_rvalid, 1'b0);
    chk({tag, "_req"},    periph_req,   4'b0000);
  endtask

  initial begin
    reset_n = 1'b0;
    {bmain_cvalid_bmmio, bmain_cmd, bmain_wvalid_bmmio, bmain_wlast} = '0;
    {bmain_rready_bmmio, bmain_eack_bmmio} = '0;
    bmain_addr = '0; bmain_wdata = '0; bmain_wmask = '0;
    periph_ack = '0; periph_rdata = '0;
    tick(); tick();
    check_idle("rst");
    chk("rst_wready", bmmio_wready, 1'b0);
    chk("rst_we",     periph_we,    1'b0);
    chk("rst_rdata",  bmmio_rdata,  32'h0);
    reset_n = 1'b1;
    tick();

    // 1) read slot1 offset 1, ack on the 4th req cycle; stray slot0 ack ignored
    send_cmd(1'b1, 32'h0200_0104);
    chk("t1_req",    periph_req,   4'b0010);
    chk("t1_addr",   periph_addr,  6'd1);
    chk("t1_we",     periph_we,    1'b0);
    chk("t1_cready", bmmio_cready, 1'b0);
    periph_ack = 4'b0001;
    tick();
    periph_ack = 4'b0000;
    chk("t1_stray",  periph_req,   4'b0010);
    tick(); tick();
    chk("t1_held",   periph_req,   4'b0010);
    periph_rdata[63:32] = 32'hdead_beef;
    periph_ack = 4'b0010;
    tick();
    periph_ack = 4'b0000;
    periph_rdata = '0;
    chk("t1_rvalid", bmmio_rvalid, 1'b1);
    chk("t1_rdata",  bmmio_rdata,  32'hdead_beef);
    chk("t1_reqoff", periph_req,   4'b0000);
    tick();
    chk("t1_rhold",  bmmio_rvalid, 1'b1);
    bmain_rready_bmmio = 1'b1;
    tick();
    bmain_rready_bmmio = 1'b0;
    check_idle("t1_done");

    // 2) write slot0 offset 2, ack on first req cycle
    send_cmd(1'b0, 32'h0200_0008);
    chk("t2_wready", bmmio_wready, 1'b1);
    chk("t2_cready", bmmio_cready, 1'b0);
    bmain_wvalid_bmmio = 1'b1; bmain_wlast = 1'b1;
    bmain_wdata = 32'h1234_5678; bmain_wmask = 4'b0011;
    tick();
    bmain_wvalid_bmmio = 1'b0; bmain_wlast = 1'b0;
    chk("t2_req",    periph_req,   4'b0001);
    chk("t2_we",     periph_we,    1'b1);
    chk("t2_wmask",  periph_wmask, 4'b0011);
    chk("t2_wdata",  periph_wdata, 32'h1234_5678);
    chk("t2_addr",   periph_addr,  6'd2);
    chk("t2_wready0", bmmio_wready, 1'b0);
    periph_ack = 4'b0001;
    tick();
    periph_ack = 4'b0000;
    check_idle("t2_done");

    // 3) read unmapped slot 15
    send_cmd(1'b1, 32'h0200_0f00);
    for (int i = 0; i < 5; i++) begin
      chk("t3_error", bmmio_error, 1'b1);
      chk("t3_req",   periph_req,  4'b0000);
      if (i < 4) tick();
    end
    bmain_eack_bmmio = 1'b1;
    tick();
    bmain_eack_bmmio = 1'b0;
    check_idle("t3_done");

    // 4) read slot2 never acked: req exactly 8 cycles then error
    send_cmd(1'b1, 32'h0200_0200);
    req_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      if (periph_req == 4'b0100) begin
        req_cycles++;
        tick();
      end
    end
    chk("t4_cycles", req_cycles,   8);
    chk("t4_error",  bmmio_error,  1'b1);
    chk("t4_req",    periph_req,   4'b0000);
    chk("t4_rvalid", bmmio_rvalid, 1'b0);
    bmain_eack_bmmio = 1'b1;
    tick();
    bmain_eack_bmmio = 1'b0;
    check_idle("t4_done");

    // 4b) ack on the 8th (last) req cycle still completes the read
    send_cmd(1'b1, 32'h0200_0204);
    for (int i = 0; i < 7; i++) tick();
    chk("t4b_last",  periph_req, 4'b0100);
    periph_rdata[95:64] = 32'h0bad_f00d;
    periph_ack = 4'b0100;
    tick();
    periph_ack = 4'b0000;
    chk("t4b_rvalid", bmmio_rvalid, 1'b1);
    chk("t4b_error",  bmmio_error,  1'b0);
    chk("t4b_rdata",  bmmio_rdata,  32'h0bad_f00d);
    bmain_rready_bmmio = 1'b1;
    tick();
    bmain_rready_bmmio = 1'b0;
    check_idle("t4b_done");

    // 5) burst write rejected
    send_cmd(1'b0, 32'h0200_0010);
    bmain_wvalid_bmmio = 1'b1; bmain_wlast = 1'b0; bmain_wdata = 32'h5555_aaaa;
    tick();
    bmain_wvalid_bmmio = 1'b0;
    chk("t5_error",  bmmio_error,  1'b1);
    chk("t5_req",    periph_req,   4'b0000);
    chk("t5_wready", bmmio_wready, 1'b0);
    tick();
    chk("t5_req2",   periph_req,   4'b0000);
    bmain_eack_bmmio = 1'b1;
    tick();
    bmain_eack_bmmio = 1'b0;
    check_idle("t5_done");

    // 6) reset during ACCESS, then during RESP, then a clean read
    send_cmd(1'b1, 32'h0200_0100);
    chk("t6_req",   periph_req, 4'b0010);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check_idle("t6_rstA");
    chk("t6_we0",   periph_we, 1'b0);
    send_cmd(1'b1, 32'h0200_0300);
    periph_rdata[127:96] = 32'hcafe_f00d;
    periph_ack = 4'b1000;
    tick();
    periph_ack = 4'b0000;
    chk("t6_rvalid", bmmio_rvalid, 1'b1);
    chk("t6_rdata",  bmmio_rdata,  32'hcafe_f00d);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check_idle("t6_rstR");
    chk("t6_rdata0", bmmio_rdata, 32'h0);
    send_cmd(1'b1, 32'h0200_0108);
    chk("t6_addr", periph_addr, 6'd2);
    periph_rdata[63:32] = 32'h0123_4567;
    periph_ack = 4'b0010;
    tick();
    periph_ack = 4'b0000;
    chk("t6_rvalid2", bmmio_rvalid, 1'b1);
    chk("t6_rdata2",  bmmio_rdata,  32'h0123_4567);
    bmain_rready_bmmio = 1'b1;
    tick();
    bmain_rready_bmmio = 1'b0;
    check_idle("t6_done");

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
